// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
// Central stall/flush controller for the 5-stage RISC-V pipeline. Drives one
// stall code (Pass/Hold/Bubb) per pipeline register from the memory-busy,
// fetch-busy, load-use and branch-flush conditions. A RUN/DRAIN FSM discards
// a wrong-path fetch that was in flight when a branch was taken, and a
// watchdog raises a sticky flag when a memory access never completes.
//
// Optional feature macro: STALL_CNT_EN
//   When defined, adds stall_cyc_o / flush_cnt_o performance counters.
// -----------------------------------------------------------------------------
module pipe_stall_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_busy_i,
    input  logic       if_busy_i,
    input  logic       ld_use_i,
    input  logic       br_flush_i,
    output logic [1:0] pc_stall_o,
    output logic [1:0] if_id_stall_o,
    output logic [1:0] id_ex_stall_o,
    output logic [1:0] ex_mem_stall_o,
    output logic [1:0] mem_wb_stall_o,
    output logic       mem_timeout_o
`ifdef STALL_CNT_EN
    ,
    output logic [31:0] stall_cyc_o,
    output logic [31:0] flush_cnt_o
`endif
);

    // Stall bus codes
    localparam logic [1:0] PASS = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] BUBB = 2'd2;

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e     state_q;
    state_e     state_d;
    logic [7:0] to_cnt_q;
    logic [7:0] to_cnt_d;
    logic       timeout_q;
    logic       timeout_d;

    // State register: FSM, watchdog counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            to_cnt_q  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state and stall-code decode; memory stall always dominates
    always_comb begin
        state_d        = state_q;
        pc_stall_o     = PASS;
        if_id_stall_o  = PASS;
        id_ex_stall_o  = PASS;
        ex_mem_stall_o = PASS;
        mem_wb_stall_o = PASS;
        if (!rst) begin
            pc_stall_o     = BUBB;
            if_id_stall_o  = BUBB;
            id_ex_stall_o  = BUBB;
            ex_mem_stall_o = BUBB;
            mem_wb_stall_o = BUBB;
        end else if (mem_busy_i) begin
            // MEM waits: freeze everything upstream, bubble into WB
            pc_stall_o     = HOLD;
            if_id_stall_o  = HOLD;
            id_ex_stall_o  = HOLD;
            ex_mem_stall_o = HOLD;
            mem_wb_stall_o = BUBB;
        end else begin
            case (state_q)
                RUN: begin
                    if (br_flush_i) begin
                        // Load the branch target, squash the two younger stages
                        pc_stall_o    = PASS;
                        if_id_stall_o = BUBB;
                        id_ex_stall_o = BUBB;
                        if (if_busy_i) begin
                            state_d = DRAIN;
                        end else begin
                            state_d = RUN;
                        end
                    end else if (ld_use_i) begin
                        pc_stall_o    = HOLD;
                        if_id_stall_o = HOLD;
                        id_ex_stall_o = BUBB;
                    end else if (if_busy_i) begin
                        pc_stall_o    = HOLD;
                        if_id_stall_o = BUBB;
                    end else begin
                        pc_stall_o    = PASS;
                    end
                end
                DRAIN: begin
                    // Wrong-path fetch outstanding: keep PC, drop whatever arrives
                    pc_stall_o    = HOLD;
                    if_id_stall_o = BUBB;
                    if (!if_busy_i) begin
                        state_d = RUN;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                default: begin
                    state_d        = RUN;
                    pc_stall_o     = BUBB;
                    if_id_stall_o  = BUBB;
                    id_ex_stall_o  = BUBB;
                    ex_mem_stall_o = BUBB;
                    mem_wb_stall_o = BUBB;
                end
            endcase
        end
    end

    // Watchdog: count consecutive busy cycles, saturate, latch the flag
    always_comb begin
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
        if (mem_busy_i) begin
            if (to_cnt_q < TO_LIMIT) begin
                to_cnt_d = to_cnt_q + 8'd1;
            end else begin
                to_cnt_d = to_cnt_q;
            end
            if (to_cnt_d == TO_LIMIT) begin
                timeout_d = 1'b1;
            end else begin
                timeout_d = timeout_q;
            end
        end else begin
            to_cnt_d = 8'd0;
        end
    end

    assign mem_timeout_o = timeout_q;

`ifdef STALL_CNT_EN
    logic [31:0] stall_cyc_q;
    logic [31:0] flush_cnt_q;
    logic        flush_take_s;

    assign flush_take_s = (state_q == RUN) && !mem_busy_i && br_flush_i;

    // Performance counters: PC-stall cycles and accepted flushes, wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cyc_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (pc_stall_o != PASS) begin
                stall_cyc_q <= stall_cyc_q + 32'd1;
            end
            if (flush_take_s) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cyc_o = stall_cyc_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl (TIMEOUT = 4). A behavioural model
// derived from the priority rules is compared every cycle, and directed
// steps pin literal codes. Codes are packed {PC, IF/ID, ID/EX, EX/MEM, MEM/WB}.
module tb_pipe_stall_ctrl;
    localparam int TO = 4;
    localparam logic [1:0] P = 2'd0;
    localparam logic [1:0] H = 2'd1;
    localparam logic [1:0] B = 2'd2;
    localparam logic [9:0] ALL_PASS = 10'b00_00_00_00_00;
    localparam logic [9:0] ALL_BUBB = 10'b10_10_10_10_10;
    localparam logic [9:0] C_MEM    = 10'b01_01_01_01_10;
    localparam logic [9:0] C_FLUSH  = 10'b00_10_10_00_00;
    localparam logic [9:0] C_LDUSE  = 10'b01_01_10_00_00;
    localparam logic [9:0] C_FETCH  = 10'b01_10_00_00_00;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_busy_i = 1'b0, if_busy_i = 1'b0, ld_use_i = 1'b0, br_flush_i = 1'b0;
    logic [1:0] pc_s, ifid_s, idex_s, exmem_s, memwb_s;
    logic mem_timeout_o;
`ifdef STALL_CNT_EN
    logic [31:0] stall_cyc_o, flush_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    pipe_stall_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_busy_i(mem_busy_i), .if_busy_i(if_busy_i),
        .ld_use_i(ld_use_i), .br_flush_i(br_flush_i),
        .pc_stall_o(pc_s), .if_id_stall_o(ifid_s), .id_ex_stall_o(idex_s),
        .ex_mem_stall_o(exmem_s), .mem_wb_stall_o(memwb_s),
        .mem_timeout_o(mem_timeout_o)
`ifdef STALL_CNT_EN
        , .stall_cyc_o(stall_cyc_o), .flush_cnt_o(flush_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    wire [9:0] dut_codes = {pc_s, ifid_s, idex_s, exmem_s, memwb_s};

    // ---------------- behavioural model ----------------
    bit          m_wrong_path = 1'b0;   // a wrong-path fetch is outstanding
    int          m_busy_run   = 0;      // consecutive busy cycles seen
    bit          m_flag       = 1'b0;
    int unsigned m_stall_cyc  = 0;
    int unsigned m_flush_cnt  = 0;

    function automatic logic [9:0] rule_codes(input bit wp, input bit mb, input bit ib,
                                              input bit lu, input bit bf);
        if (mb) return {H, H, H, H, B};
        if (wp) return {H, B, P, P, P};
        if (bf) return {P, B, B, P, P};
        if (lu) return {H, H, B, P, P};
        if (ib) return {H, B, P, P, P};
        return {P, P, P, P, P};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        logic [9:0] e;
        if (!rst) begin
            m_wrong_path = 1'b0;
            m_busy_run   = 0;
            m_flag       = 1'b0;
            m_stall_cyc  = 0;
            m_flush_cnt  = 0;
        end else begin
            e = rule_codes(m_wrong_path, mem_busy_i, if_busy_i, ld_use_i, br_flush_i);
            if (e[9:8] != P) m_stall_cyc++;
            if (!m_wrong_path && !mem_busy_i && br_flush_i) m_flush_cnt++;
            m_busy_run = mem_busy_i ? m_busy_run + 1 : 0;
            if (m_busy_run >= TO) m_flag = 1'b1;
            if (!m_wrong_path) m_wrong_path = !mem_busy_i && br_flush_i && if_busy_i;
            else if (!mem_busy_i && !if_busy_i) m_wrong_path = 1'b0;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic [9:0] e;
        e = rst ? rule_codes(m_wrong_path, mem_busy_i, if_busy_i, ld_use_i, br_flush_i) : ALL_BUBB;
        check("model_codes", {22'd0, dut_codes}, {22'd0, e});
        check("model_timeout", {31'd0, mem_timeout_o}, {31'd0, m_flag});
`ifdef STALL_CNT_EN
        check("model_stall_cyc", stall_cyc_o, m_stall_cyc);
        check("model_flush_cnt", flush_cnt_o, m_flush_cnt);
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input bit mb, input bit ib, input bit lu, input bit bf);
        @(posedge clk);
        #1;
        mem_busy_i = mb; if_busy_i = ib; ld_use_i = lu; br_flush_i = bf;
        #1;
    endtask

    task automatic lit(input string name, input logic [9:0] exp);
        check(name, {22'd0, dut_codes}, {22'd0, exp});
    endtask

    initial begin
        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            lit("reset_bubb", ALL_BUBB);
            check("reset_timeout", {31'd0, mem_timeout_o}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1; mem_busy_i = 0; if_busy_i = 0; ld_use_i = 0; br_flush_i = 0;
        #1;
        lit("release_pass", ALL_PASS);

        // Load-use for one cycle
        drive(0, 0, 1, 0); lit("lduse", C_LDUSE);
        drive(0, 0, 0, 0); lit("lduse_after", ALL_PASS);

        // Flush during fetch, then three more busy fetch cycles and one idle
        drive(0, 1, 0, 1); lit("flush_accept", C_FLUSH);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 1); lit("drain_busy", C_FETCH);
        end
        drive(0, 0, 1, 1); lit("drain_last", C_FETCH);
        drive(0, 0, 0, 0); lit("drain_done", ALL_PASS);
`ifdef STALL_CNT_EN
        check("flush_cnt_one", flush_cnt_o, 32'd1);
`endif

        // Memory stall while draining
        drive(0, 1, 0, 1); lit("flush2_accept", C_FLUSH);
        drive(1, 1, 0, 0); lit("drain_mem", C_MEM);
        drive(1, 0, 0, 0); lit("drain_mem2", C_MEM);
        drive(0, 0, 0, 0); lit("drain_exit", C_FETCH);
        drive(0, 0, 0, 0); lit("drain_exit_run", ALL_PASS);

        // Watchdog: 3 busy cycles stay clear, 4 set the flag
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("wd_three", {31'd0, mem_timeout_o}, 32'd0);
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("wd_four", {31'd0, mem_timeout_o}, 32'd1);
        drive(0, 0, 0, 0);
        check("wd_sticky", {31'd0, mem_timeout_o}, 32'd1);

        // Memory busy with branch held: rule 1 wins, flush exactly once after
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 1); lit("mem_br_hold", C_MEM);
        end
        drive(0, 0, 0, 1); lit("mem_br_flush", C_FLUSH);
        drive(0, 0, 0, 0); lit("mem_br_after", ALL_PASS);

        // Reset asserted while in DRAIN
        drive(0, 1, 0, 1); lit("flush3_accept", C_FLUSH);
        drive(0, 1, 0, 0); lit("drain3", C_FETCH);
        #1;
        rst = 1'b0;
        #1;
        lit("rst_in_drain", ALL_BUBB);
        check("rst_timeout_clr", {31'd0, mem_timeout_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1; mem_busy_i = 0; if_busy_i = 0; ld_use_i = 0; br_flush_i = 0;
        #1;
        lit("rst_release_pass", ALL_PASS);

        // Pseudo-random traffic checked by the model
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        end
        drive(0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
